// File: rtl/data_stack.sv
// -----------------------------------------------------------------------------
// data_stack
//   LIFO data stack with a registered pop output, a combinational top-of-stack
//   view and sticky overflow/underflow flags.
//
// Ports
//   clk            : rising-edge clock for every state change
//   rst            : asynchronous, active-low reset
//   rst_stack      : synchronous clear (wins over push/pop in the same cycle)
//   push_stack     : push stack_data_in this cycle
//   pop_stack      : pop the top entry this cycle
//   stack_data_in  : word to push
//   stack_data_out : registered copy of the most recently popped word
//   tos            : current top entry, 0 when empty
//   count          : number of valid entries (0..DEPTH)
//   empty / full   : count == 0 / count == DEPTH
//   overflow       : sticky, set by a push while full
//   underflow      : sticky, set by a pop while empty
//
// Command semantics: push_stack and pop_stack are single-cycle requests
// sampled on the rising edge of clk. There is no ready/backpressure; every
// request is consumed on the edge where it is seen. A request that cannot be
// honoured (push while full, pop while empty) leaves the stack unchanged and
// sets the matching sticky flag instead. Push+pop on a non-empty stack is a
// replace of the top entry, and the old top is returned on stack_data_out.
// -----------------------------------------------------------------------------
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_stack,
  input  logic             push_stack,
  input  logic             pop_stack,
  input  logic [WIDTH-1:0] stack_data_in,
  output logic [WIDTH-1:0] stack_data_out,
  output logic [WIDTH-1:0] tos,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Storage has no reset: contents are never visible while count is 0.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_unf;

  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_empty;
  logic             w_full;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  // count-1 wraps to all ones when empty; tos is masked in that case.
  assign w_top_idx = AW'(r_count - CNT_W'(1));
  // Only used when not full, so count fits in AW bits here.
  assign w_wr_idx  = AW'(r_count);

  always_comb begin
    w_count_nxt = r_count;
    w_dout_nxt  = r_dout;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_we        = 1'b0;
    w_waddr     = w_wr_idx;

    if (rst_stack) begin
      w_count_nxt = '0;
      w_dout_nxt  = '0;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
    end else if (push_stack && pop_stack) begin
      if (w_empty) begin
        // Nothing to pop: the push still lands in entry 0.
        w_we        = 1'b1;
        w_waddr     = w_wr_idx;
        w_count_nxt = CNT_W'(1);
        w_unf_nxt   = 1'b1;
      end else begin
        // Replace top; old top goes out. Works when full too.
        w_dout_nxt = r_mem[w_top_idx];
        w_we       = 1'b1;
        w_waddr    = w_top_idx;
      end
    end else if (push_stack) begin
      if (w_full) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_we        = 1'b1;
        w_waddr     = w_wr_idx;
        w_count_nxt = r_count + CNT_W'(1);
      end
    end else if (pop_stack) begin
      if (w_empty) begin
        w_unf_nxt = 1'b1;
      end else begin
        w_dout_nxt  = r_mem[w_top_idx];
        w_count_nxt = r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_dout  <= w_dout_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // A write while rst is low is harmless: count stays 0, so it is never read.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= stack_data_in;
    end
  end

  assign stack_data_out = r_dout;
  assign tos            = w_empty ? '0 : r_mem[w_top_idx];
  assign count          = r_count;
  assign empty          = w_empty;
  assign full           = w_full;
  assign overflow       = r_ovf;
  assign underflow      = r_unf;

endmodule

// File: tb/tb_data_stack.sv
// -----------------------------------------------------------------------------
// tb_data_stack
//   Directed bench for data_stack (WIDTH=16, DEPTH=16). The driver applies one
//   operation per cycle and queues the hand-computed post-edge state; the
//   monitor compares the queued state against the DUT on each falling edge.
// -----------------------------------------------------------------------------
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  // Packed snapshot: {count, stack_data_out, tos, empty, full, overflow, underflow}
  localparam int W = CNT_W + 2*WIDTH + 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             rst_stack;
  logic             push_stack;
  logic             pop_stack;
  logic [WIDTH-1:0] stack_data_in;
  logic [WIDTH-1:0] stack_data_out;
  logic [WIDTH-1:0] tos;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  always #5 clk = ~clk;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rst_stack      (rst_stack),
    .push_stack     (push_stack),
    .pop_stack      (pop_stack),
    .stack_data_in  (stack_data_in),
    .stack_data_out (stack_data_out),
    .tos            (tos),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  function automatic logic [W-1:0] pack(input logic [CNT_W-1:0] c, input logic [WIDTH-1:0] d,
                                        input logic [WIDTH-1:0] t, input logic e, input logic f,
                                        input logic o, input logic u);
    return {c, d, t, e, f, o, u};
  endfunction

  task automatic expect_state(input string nm, input logic [CNT_W-1:0] c, input logic [WIDTH-1:0] d,
                              input logic [WIDTH-1:0] t, input logic e, input logic f,
                              input logic o, input logic u);
    exp_q.push_back(pack(c, d, t, e, f, o, u));
    name_q.push_back(nm);
  endtask

  // Monitor: one comparison per queued expectation, on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e_v;
      logic [W-1:0] a_v;
      string        nm;
      e_v = exp_q.pop_front();
      nm  = name_q.pop_front();
      a_v = pack(count, stack_data_out, tos, empty, full, overflow, underflow);
      n_tests++;
      if (a_v !== e_v) begin
        n_fail++;
        $display("FAIL %s: got cnt=%0d out=%h tos=%h e=%b f=%b ovf=%b unf=%b, want cnt=%0d out=%h tos=%h e=%b f=%b ovf=%b unf=%b",
                 nm, a_v[W-1 -: CNT_W], a_v[2*WIDTH+3 -: WIDTH], a_v[WIDTH+3 -: WIDTH],
                 a_v[3], a_v[2], a_v[1], a_v[0],
                 e_v[W-1 -: CNT_W], e_v[2*WIDTH+3 -: WIDTH], e_v[WIDTH+3 -: WIDTH],
                 e_v[3], e_v[2], e_v[1], e_v[0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic p, input logic po, input logic c, input logic [WIDTH-1:0] d);
    @(negedge clk);
    push_stack    = p;
    pop_stack     = po;
    rst_stack     = c;
    stack_data_in = d;
    @(posedge clk);
    #1;
    push_stack    = 1'b0;
    pop_stack     = 1'b0;
    rst_stack     = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b0;
    rst_stack     = 1'b0;
    push_stack    = 1'b0;
    pop_stack     = 1'b0;
    stack_data_in = '0;

    expect_state("reset", 5'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Basic push/push/pop/pop
    drive(1, 0, 0, 16'h0005); expect_state("push5",  5'd1, 16'h0000, 16'h0005, 0, 0, 0, 0);
    drive(1, 0, 0, 16'h0007); expect_state("push7",  5'd2, 16'h0000, 16'h0007, 0, 0, 0, 0);
    drive(0, 1, 0, 16'h0000); expect_state("pop7",   5'd1, 16'h0007, 16'h0005, 0, 0, 0, 0);
    drive(0, 1, 0, 16'h0000); expect_state("pop5",   5'd0, 16'h0005, 16'h0000, 1, 0, 0, 0);
    drive(0, 0, 0, 16'h1234); expect_state("idle",   5'd0, 16'h0005, 16'h0000, 1, 0, 0, 0);

    // Underflow from empty, and its stickiness
    drive(0, 0, 1, 16'h0000); expect_state("clr1",   5'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    drive(0, 1, 0, 16'h0000); expect_state("unf",    5'd0, 16'h0000, 16'h0000, 1, 0, 0, 1);
    drive(1, 0, 0, 16'h0003); expect_state("unf_sticky", 5'd1, 16'h0000, 16'h0003, 0, 0, 0, 1);

    // Simultaneous push/pop on count 1
    drive(0, 0, 1, 16'h0000); expect_state("clr2",   5'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    drive(1, 0, 0, 16'h0003); expect_state("push3",  5'd1, 16'h0000, 16'h0003, 0, 0, 0, 0);
    drive(1, 1, 0, 16'h0009); expect_state("pushpop", 5'd1, 16'h0003, 16'h0009, 0, 0, 0, 0);

    // Fill to full, then overflow
    drive(0, 0, 1, 16'h0000); expect_state("clr3",   5'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 16'h0100 + 16'(i));
      expect_state($sformatf("fill%0d", i), 5'(i + 1), 16'h0000, 16'h0100 + 16'(i),
                   0, (i == DEPTH - 1), 0, 0);
    end
    drive(1, 0, 0, 16'hFFFF); expect_state("ovf",    5'd16, 16'h0000, 16'h010F, 0, 1, 1, 0);
    drive(0, 1, 0, 16'h0000); expect_state("pop_full", 5'd15, 16'h010F, 16'h010E, 0, 0, 1, 0);
    drive(1, 0, 0, 16'h0AAA); expect_state("refill", 5'd16, 16'h010F, 16'h0AAA, 0, 1, 1, 0);
    drive(1, 1, 0, 16'h0BBB); expect_state("pushpop_full", 5'd16, 16'h0AAA, 16'h0BBB, 0, 1, 1, 0);

    // Push+pop while empty
    drive(0, 0, 1, 16'h0000); expect_state("clr4",   5'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    drive(1, 1, 0, 16'h0042); expect_state("pushpop_empty", 5'd1, 16'h0000, 16'h0042, 0, 0, 0, 1);

    // Clear wins over push
    drive(1, 0, 0, 16'h0001); expect_state("p1",     5'd2, 16'h0000, 16'h0001, 0, 0, 0, 1);
    drive(1, 0, 0, 16'h0002); expect_state("p2",     5'd3, 16'h0000, 16'h0002, 0, 0, 0, 1);
    drive(1, 0, 0, 16'h0003); expect_state("p3",     5'd4, 16'h0000, 16'h0003, 0, 0, 0, 1);
    drive(0, 1, 0, 16'h0000); expect_state("pop3",   5'd3, 16'h0003, 16'h0002, 0, 0, 0, 1);
    drive(1, 0, 1, 16'h0077); expect_state("clr_push", 5'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    drive(0, 0, 0, 16'h0000); expect_state("clr_idle", 5'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);

    // Async reset between edges at count 4
    drive(1, 0, 0, 16'h000A); expect_state("a1",     5'd1, 16'h0000, 16'h000A, 0, 0, 0, 0);
    drive(1, 0, 0, 16'h000B); expect_state("a2",     5'd2, 16'h0000, 16'h000B, 0, 0, 0, 0);
    drive(1, 0, 0, 16'h000C); expect_state("a3",     5'd3, 16'h0000, 16'h000C, 0, 0, 0, 0);
    drive(1, 0, 0, 16'h000D); expect_state("a4",     5'd4, 16'h0000, 16'h000D, 0, 0, 0, 0);
    drive(0, 1, 0, 16'h0000); expect_state("a_pop",  5'd3, 16'h000D, 16'h000C, 0, 0, 0, 0);
    drive(1, 0, 0, 16'h000E); expect_state("a5",     5'd4, 16'h000D, 16'h000E, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    // Checked on the next falling edge, before any further rising edge.
    expect_state("async_rst", 5'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    @(negedge clk);
    // A push during reset must be discarded.
    push_stack    = 1'b1;
    stack_data_in = 16'h0099;
    @(posedge clk);
    #1;
    push_stack = 1'b0;
    expect_state("rst_discard", 5'd0, 16'h0000, 16'h0000, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 16'h0055); expect_state("post_rst_push", 5'd1, 16'h0000, 16'h0055, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of stack entries (power of two, >= 2).
REQ-003 Parameter CNT_W, default 5: width of count, equal to clog2(DEPTH+1).
REQ-004 clk  input  1: single clock; all state changes occur on its rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-low.
REQ-006 rst_stack  input  1: synchronous clear request from control FSM.
REQ-007 push_stack  input  1: push stack_data_in this cycle.
REQ-008 pop_stack  input  1: pop top entry this cycle.
REQ-009 stack_data_in  input  WIDTH: word to push.
REQ-010 stack_data_out  output  WIDTH: registered value of the last popped word.
REQ-011 tos  output  WIDTH: combinational current top entry, 0 when empty.
REQ-012 count  output  CNT_W: number of valid entries, 0..DEPTH.
REQ-013 empty / full  output  1 each: count==0 / count==DEPTH.
REQ-014 overflow / underflow  output  1 each: sticky error flags.

Function
REQ-015 Storage: DEPTH x WIDTH register array; internal pointer sp equals count; entry sp-1 is the top.
REQ-016 Push only (push=1, pop=0, not full): mem[sp] <= stack_data_in, count +1; stack_data_out unchanged.
REQ-017 Pop only (pop=1, push=0, not empty): stack_data_out <= mem[sp-1], count -1; the value is visible the cycle after the pop edge and held until the next successful pop or clear.
REQ-018 Push while full: no write, count unchanged, overflow <= 1.
REQ-019 Pop while empty: stack_data_out and count unchanged, underflow <= 1.
REQ-020 Simultaneous push and pop, not empty (full included): stack_data_out <= old mem[sp-1], mem[sp-1] <= stack_data_in, count unchanged, no error flag.
REQ-021 Simultaneous push and pop while empty: push performed (count becomes 1), stack_data_out unchanged, underflow <= 1.
REQ-022 rst_stack=1 has priority over push/pop in the same cycle: count <= 0, stack_data_out <= 0, overflow <= 0, underflow <= 0; array contents need not be cleared.
REQ-023 overflow and underflow remain 1 until rst_stack or rst; they never self-clear.
REQ-024 tos, empty and full derive combinationally from registered count and array only; there is no combinational path from any input to any output.
REQ-025 Pointer arithmetic never wraps: count saturates at legal bounds via REQ-018/019, never exceeding DEPTH or falling below 0.
REQ-026 Idle cycle (push=0, pop=0, rst_stack=0): all state held.

Reset
REQ-027 On rst low, immediately and independently of clk: count=0, stack_data_out=0, overflow=0, underflow=0; thus empty=1, full=0, tos=0.
REQ-028 rst asserted mid-operation discards any push/pop of that cycle; first operation is accepted on the first rising edge after rst returns high.
REQ-029 Array contents are undefined after rst and never observable, since tos reads 0 when empty.

Verification
REQ-030 Reset then push 0x0005, 0x0007, pop, pop -> stack_data_out 0x0007 then 0x0005, count 2,1,0, empty=1 at end, no flags.
REQ-031 Push 16 values 0x0100..0x010F (DEPTH=16), then push 0xFFFF -> full=1, count 16, overflow=1, tos=0x010F; subsequent pop -> stack_data_out 0x010F.
REQ-032 From empty, pop -> underflow=1, stack_data_out stays 0, count 0; overflow remains 0.
REQ-033 Stack holds 0x0003 (count 1); assert push 0x0009 and pop together -> stack_data_out 0x0003, tos 0x0009, count 1, no flags.
REQ-034 Stack count 3 with underflow=1; assert rst_stack with push_stack=1 -> next cycle count 0, flags 0, stack_data_out 0, nothing pushed.
REQ-035 Drop rst low asynchronously between clock edges while count 4 -> outputs return to reset values before the next edge; first push after release gives count 1.
